// File: rtl/if_fetch_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_pkg
// Shared definitions for the instruction fetch stage and its decoder partner:
//   - NOP_INSTR   : encoding of LLB R0,#0, presented while no fetch is valid
//   - fetch_state_e : BOOT / RUN / HOLD state encodings
//   - CNT_W       : width of the optional performance counters
//   - sat_inc     : saturating increment used by the performance counters
// -----------------------------------------------------------------------------
package if_fetch_pkg;

  localparam logic [15:0] NOP_INSTR = 16'hB000;
  localparam int          CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/if_perf_cnt.sv
// -----------------------------------------------------------------------------
// if_perf_cnt
// Two 16-bit saturating event counters for the fetch stage.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (clears counters)
//   inc_fetch         : one cycle with an instruction-memory read issued
//   inc_redir         : one cycle with a control-flow redirect
//   ifetch_cnt        : saturating count of inc_fetch cycles
//   redir_cnt         : saturating count of inc_redir cycles
// Only built when IF_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module if_perf_cnt
  import if_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_fetch,
  input  logic             inc_redir,
  output logic [CNT_W-1:0] ifetch_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  logic [CNT_W-1:0] ifetch_cnt_r;
  logic [CNT_W-1:0] redir_cnt_r;

  // Counter registers: bump on each event, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifetch_cnt_r <= {CNT_W{1'b0}};
      redir_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (inc_fetch) begin
        ifetch_cnt_r <= sat_inc(ifetch_cnt_r);
      end else begin
        ifetch_cnt_r <= ifetch_cnt_r;
      end
      if (inc_redir) begin
        redir_cnt_r <= sat_inc(redir_cnt_r);
      end else begin
        redir_cnt_r <= redir_cnt_r;
      end
    end
  end

  assign ifetch_cnt = ifetch_cnt_r;
  assign redir_cnt  = redir_cnt_r;

endmodule

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
// Instruction fetch stage of the 16-bit five-stage pipeline. Generates the PC
// and read strobe for a synchronous instruction memory (data one cycle after
// the read) and presents each fetched word plus its address+1 to decode.
// Honours the decoder stall without dropping or duplicating instructions and
// redirects on a taken branch / JAL / JR from EX.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall_IM_ID         : decoder is not accepting instr this cycle
//   flow_change_ID_EX   : redirect request (priority over stall)
//   dst_ID_EX           : redirect target
//   i_rd, iaddr         : IM read enable / address (combinational)
//   i_rdata             : IM read data, valid the cycle after i_rd
//   instr, nxt_pc       : instruction and its address+1 to decode (mux, not flopped)
//   ifetch_cnt          : read-issued cycle count (0 unless IF_PERF_CNT_EN)
//   redir_cnt           : redirect count          (0 unless IF_PERF_CNT_EN)
// Build option: define IF_PERF_CNT_EN to build the saturating counters.
// -----------------------------------------------------------------------------
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_IM_ID,
  input  logic            flow_change_ID_EX,
  input  logic [PC_W-1:0] dst_ID_EX,
  output logic            i_rd,
  output logic [PC_W-1:0] iaddr,
  input  logic [15:0]     i_rdata,
  output logic [15:0]     instr,
  output logic [PC_W-1:0] nxt_pc,
  output logic [15:0]     ifetch_cnt,
  output logic [15:0]     redir_cnt
);

  // PC increment, modulo 2^PC_W (all-ones wraps to zero).
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] a);
    return a + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

  fetch_state_e    state_r;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] rd_npc_r;
  logic [15:0]     hold_instr_r;
  logic [PC_W-1:0] hold_npc_r;

  logic            i_rd_s;
  logic [PC_W-1:0] iaddr_s;
  logic [15:0]     instr_s;
  logic [PC_W-1:0] nxt_pc_s;

  // Read request: a redirect always fetches its target; otherwise every state
  // issues at pc whenever decode accepts. Held off while in reset.
  always_comb begin
    i_rd_s  = 1'b0;
    iaddr_s = pc_r;
    if (flow_change_ID_EX) begin
      iaddr_s = dst_ID_EX;
      i_rd_s  = rst_n;
    end else begin
      iaddr_s = pc_r;
      i_rd_s  = rst_n & ~stall_IM_ID;
    end
  end

  // Decode-facing mux: live memory data in RUN, skid copy in HOLD, NOP in BOOT.
  always_comb begin
    instr_s  = NOP_INSTR;
    nxt_pc_s = RESET_PC;
    case (state_r)
      ST_BOOT: begin
        instr_s  = NOP_INSTR;
        nxt_pc_s = RESET_PC;
      end
      ST_RUN: begin
        instr_s  = i_rdata;
        nxt_pc_s = rd_npc_r;
      end
      ST_HOLD: begin
        instr_s  = hold_instr_r;
        nxt_pc_s = hold_npc_r;
      end
      default: begin
        instr_s  = NOP_INSTR;
        nxt_pc_s = RESET_PC;
      end
    endcase
  end

  // Fetch FSM and PC bookkeeping. rd_npc_r always tracks (address in flight)+1
  // so nxt_pc lines up with the word arriving on i_rdata next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_BOOT;
      pc_r         <= RESET_PC;
      rd_npc_r     <= RESET_PC;
      hold_instr_r <= NOP_INSTR;
      hold_npc_r   <= RESET_PC;
    end else if (flow_change_ID_EX) begin
      // Redirect wins over stall; anything held is discarded.
      pc_r     <= pc_inc(dst_ID_EX);
      rd_npc_r <= pc_inc(dst_ID_EX);
      state_r  <= ST_RUN;
    end else begin
      case (state_r)
        ST_BOOT: begin
          if (!stall_IM_ID) begin
            pc_r     <= pc_inc(pc_r);
            rd_npc_r <= pc_inc(pc_r);
            state_r  <= ST_RUN;
          end else begin
            state_r  <= ST_BOOT;
          end
        end
        ST_RUN: begin
          if (!stall_IM_ID) begin
            pc_r     <= pc_inc(pc_r);
            rd_npc_r <= pc_inc(pc_r);
            state_r  <= ST_RUN;
          end else begin
            // The word on i_rdata is only valid this cycle; park it.
            hold_instr_r <= i_rdata;
            hold_npc_r   <= rd_npc_r;
            state_r      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!stall_IM_ID) begin
            // Decode takes the held word now; the next read overlaps it.
            pc_r     <= pc_inc(pc_r);
            rd_npc_r <= pc_inc(pc_r);
            state_r  <= ST_RUN;
          end else begin
            state_r  <= ST_HOLD;
          end
        end
        default: begin
          state_r <= ST_BOOT;
        end
      endcase
    end
  end

  assign i_rd   = i_rd_s;
  assign iaddr  = iaddr_s;
  assign instr  = instr_s;
  assign nxt_pc = nxt_pc_s;

`ifdef IF_PERF_CNT_EN
  if_perf_cnt u_perf_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_fetch  (i_rd_s),
    .inc_redir  (flow_change_ID_EX),
    .ifetch_cnt (ifetch_cnt),
    .redir_cnt  (redir_cnt)
  );
`else
  assign ifetch_cnt = 16'h0000;
  assign redir_cnt  = 16'h0000;
`endif

endmodule
